// File: rtl/instr_fetch.sv
// Instruction fetch stage with IF/ID register for the 16-bit MEPHI CPU.
// Owns the PC, issues req/ack word reads, absorbs stalls in a one-entry skid register.
//
// state | meaning
// IDLE  | out of reset, no request; next edge starts fetching at pc
// REQ   | request at req_addr outstanding; ack loads IF/ID or the skid
// HOLD  | skid full while downstream stalls, no request issued
// DRAIN | redirected mid-request; wait out the old ack and discard it
module instr_fetch #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [15:0]   instr,
    output logic          instr_valid,
    output logic [AW-1:0] instr_pc,
    output logic [AW-1:0] pc_plus1
);

    localparam logic [15:0]   NOP = 16'hC000;
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [AW-1:0] req_addr, req_addr_nxt;
    logic [15:0]   skid_instr;
    logic [AW-1:0] skid_pc;
    logic          skid_full;
    logic          load_mem, load_skid, fill_skid;

    assign imem_addr = req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        imem_req     = 1'b0;
        load_mem     = 1'b0;
        load_skid    = 1'b0;
        fill_skid    = 1'b0;
        req_addr_nxt = req_addr;
        case (state)
            IDLE: begin
                state_nxt    = REQ;
                req_addr_nxt = redirect ? redirect_pc : pc;
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // With no ack the old request must be held until it completes
                    if (imem_ack) req_addr_nxt = redirect_pc;
                    else          state_nxt    = DRAIN;
                end else if (imem_ack) begin
                    if (stall) begin
                        fill_skid = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        load_mem     = 1'b1;
                        req_addr_nxt = req_addr + ONE;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_nxt    = REQ;
                    req_addr_nxt = redirect_pc;
                end else if (!stall && skid_full) begin
                    load_skid    = 1'b1;
                    state_nxt    = REQ;
                    req_addr_nxt = skid_pc + ONE;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (!redirect && imem_ack) begin
                    state_nxt    = REQ;
                    req_addr_nxt = pc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (redirect)       pc_nxt = redirect_pc;
        else if (load_mem)  pc_nxt = req_addr + ONE;
        else if (load_skid) pc_nxt = skid_pc + ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            skid_full  <= 1'b0;
            skid_instr <= NOP;
            skid_pc    <= '0;
        end else begin
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            if (redirect) begin
                skid_full <= 1'b0;
            end else if (fill_skid) begin
                skid_full  <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= req_addr;
            end else if (load_skid) begin
                skid_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            pc_plus1    <= ONE;
        end else if (redirect) begin
            instr       <= NOP;
            instr_valid <= 1'b0;
        end else if (load_mem) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            instr_pc    <= req_addr;
            pc_plus1    <= req_addr + ONE;
        end else if (load_skid) begin
            instr       <= skid_instr;
            instr_valid <= 1'b1;
            instr_pc    <= skid_pc;
            pc_plus1    <= skid_pc + ONE;
        end else if (!stall) begin
            // Killed or missing fetch becomes a bubble; its PC fields keep the last value
            instr       <= NOP;
            instr_valid <= 1'b0;
        end
    end

endmodule
